// File: rtl/axi_csr_pkg.sv
// axi_csr_pkg: shared definitions for the AXI CSR manager.
//   csr_state_e  - transfer sequencing states of the manager FSM
//   RESP_OKAY    - AXI BRESP/RRESP "OKAY"
//   RESP_SLVERR  - AXI BRESP/RRESP "SLVERR"
package axi_csr_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4
    } csr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_csr_manager.sv
// axi_csr_manager: single-beat, single-outstanding AXI4 manager that turns a
// simple command handshake into one AXI write or read transfer.
//   m_axi_clk / m_axi_resetn       - clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata - command request (accepted when valid&&ready)
//   rsp_valid/rdata/resp           - one-cycle completion pulse with read data / response
//   m_axi_aw*, m_axi_w*, m_axi_b*  - AXI write address, write data, write response
//   m_axi_ar*, m_axi_r*            - AXI read address, read data
// Every output is driven from a flop; the next-state and next-output logic
// is purely combinational on registered state and the AXI inputs.
module axi_csr_manager
    import axi_csr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  m_axi_clk,
    input  logic                  m_axi_resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic                  m_axi_wlast,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic                  m_axi_rlast
);

    csr_state_e            state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  cmd_ready_d, awvalid_d, wvalid_d, bready_d;
    logic                  arvalid_d, rready_d, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d, wdata_d;
    logic [1:0]            rsp_resp_d;
    logic [ADDR_WIDTH-1:0] awaddr_d, araddr_d;
    logic                  unused_rlast;

    // Transfers are single-beat, so RLAST carries no information.
    assign unused_rlast = m_axi_rlast;

    assign accept = cmd_valid && cmd_ready;
    assign aw_hs  = m_axi_awvalid && m_axi_awready;
    assign w_hs   = m_axi_wvalid  && m_axi_wready;
    // bready/rready are only high in their response states, so a stray
    // bvalid/rvalid can never form a handshake.
    assign b_hs   = m_axi_bvalid  && m_axi_bready;
    assign ar_hs  = m_axi_arvalid && m_axi_arready;
    assign r_hs   = m_axi_rvalid  && m_axi_rready;

    // Single beat: the only W beat is always the last one.
    assign m_axi_wlast = m_axi_wvalid;

    // State and output registers
    always_ff @(posedge m_axi_clk or negedge m_axi_resetn) begin
        if (!m_axi_resetn) begin
            state_q       <= IDLE;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            cmd_ready     <= 1'b1;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_araddr  <= '0;
        end else begin
            state_q       <= state_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            cmd_ready     <= cmd_ready_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_resp      <= rsp_resp_d;
            m_axi_awaddr  <= awaddr_d;
            m_axi_wdata   <= wdata_d;
            m_axi_araddr  <= araddr_d;
        end
    end

    // Next-state logic
    always_comb begin
        // AW and W complete independently; each flag remembers its own
        // handshake and is cleared whenever a new write starts from IDLE.
        aw_done_d = (state_q == WR_ADDR_DATA) && (aw_done_q || aw_hs);
        w_done_d  = (state_q == WR_ADDR_DATA) && (w_done_q  || w_hs);
        state_d   = state_q;
        unique case (state_q)
            IDLE:         if (accept) state_d = cmd_write ? WR_ADDR_DATA : RD_ADDR;
            WR_ADDR_DATA: if (aw_done_d && w_done_d) state_d = WR_RESP;
            WR_RESP:      if (b_hs) state_d = IDLE;
            RD_ADDR:      if (ar_hs) state_d = RD_DATA;
            RD_DATA:      if (r_hs) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // Next-output logic (registered above, so no output follows a READY combinationally)
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        awvalid_d   = (state_d == WR_ADDR_DATA) && !aw_done_d;
        wvalid_d    = (state_d == WR_ADDR_DATA) && !w_done_d;
        bready_d    = (state_d == WR_RESP);
        arvalid_d   = (state_d == RD_ADDR);
        rready_d    = (state_d == RD_DATA);
        rsp_valid_d = b_hs || r_hs;

        rsp_rdata_d = rsp_rdata;
        rsp_resp_d  = rsp_resp;
        if (r_hs) begin
            rsp_rdata_d = m_axi_rdata;
            rsp_resp_d  = m_axi_rresp;
        end else if (b_hs) begin
            rsp_rdata_d = '0;
            rsp_resp_d  = m_axi_bresp;
        end

        awaddr_d = m_axi_awaddr;
        wdata_d  = m_axi_wdata;
        araddr_d = m_axi_araddr;
        if (accept && cmd_write) begin
            awaddr_d = cmd_addr;
            wdata_d  = cmd_wdata;
        end
        if (accept && !cmd_write) begin
            araddr_d = cmd_addr;
        end
    end

endmodule

// File: tb/tb_axi_csr_manager.sv
// tb_axi_csr_manager: drives commands into axi_csr_manager and plays an AXI
// subordinate backed by a small memory with programmable per-channel delays.
// Expected completions come from a plain array model of the addressed space.
module tb_axi_csr_manager;
    import axi_csr_pkg::*;

    logic       m_axi_clk = 1'b0;
    logic       m_axi_resetn = 1'b0;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [7:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic       m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [1:0] m_axi_bresp, m_axi_rresp;
    logic       m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic       m_axi_rvalid, m_axi_rready, m_axi_rlast;

    always #5 m_axi_clk = ~m_axi_clk;

    axi_csr_manager #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .m_axi_clk(m_axi_clk), .m_axi_resetn(m_axi_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wlast(m_axi_wlast),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast)
    );

    localparam logic [41:0] RST_VEC = {1'b1, 41'd0};

    int         total = 0;
    int         bad = 0;
    int         aw_dly, w_dly, b_dly, ar_dly, r_dly;
    bit         stray_en;
    logic [7:0] model_mem [256];
    logic [7:0] smem [256];
    logic [7:0] last_rdata;
    logic [1:0] last_resp;

    function automatic logic [41:0] out_vec();
        return {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                m_axi_arvalid, m_axi_rready, rsp_valid, rsp_rdata, rsp_resp,
                m_axi_awaddr, m_axi_wdata, m_axi_araddr};
    endfunction

    task automatic sub_idle();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid  = 1'b0; m_axi_bresp  = 2'b00;
        m_axi_rvalid  = 1'b0; m_axi_rresp  = 2'b00; m_axi_rdata = 8'h00; m_axi_rlast = 1'b0;
    endtask

    task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    // Issue one command at the current negedge and run the subordinate until
    // the completion pulse. With chk_lat the completion must land in the 4th
    // cycle counting the accept cycle as the 1st.
    task automatic do_cmd(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                          input logic [1:0] resp, input bit chk_lat, input bit abort_rst);
        int cyc, aw_w, w_w, b_w, ar_w, r_w;
        bit aw_d, w_d, b_d, ar_d, r_d, done;
        logic [7:0] cap_addr, cap_data, exp_rdata;
        cyc = 1; aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
        aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0; done = 0;
        cap_addr = 8'h00; cap_data = 8'h00;
        exp_rdata = wr ? 8'h00 : model_mem[addr];
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge m_axi_clk);
            cyc++;
            cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
            if (abort_rst && m_axi_bready) begin
                m_axi_resetn = 1'b0;
                #1;
                total++;
                if (out_vec() !== RST_VEC) begin bad++; $display("FAIL reset_mid: outputs=%h want %h", out_vec(), RST_VEC); end
                last_rdata = 8'h00; last_resp = 2'b00;
                sub_idle();
                @(negedge m_axi_clk);
                m_axi_resetn = 1'b1;
                total++;
                if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: cmd_ready=%b want 1", cmd_ready); end
                done = 1;
            end else begin
                total++;
                if (m_axi_wlast !== m_axi_wvalid) begin bad++; $display("FAIL wlast: wlast=%b wvalid=%b", m_axi_wlast, m_axi_wvalid); end
                total++;
                if (wr) begin
                    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !==
                        {!aw_d, !w_d, aw_d && w_d && !b_d, 1'b0, 1'b0}) begin
                        bad++; $display("FAIL wr_ctl cyc%0d: aw,w,b,ar,r=%b%b%b%b%b want %b%b%b00", cyc,
                            m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                            !aw_d, !w_d, aw_d && w_d && !b_d);
                    end
                end else begin
                    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !==
                        {1'b0, 1'b0, 1'b0, !ar_d, ar_d && !r_d}) begin
                        bad++; $display("FAIL rd_ctl cyc%0d: aw,w,b,ar,r=%b%b%b%b%b want 000%b%b", cyc,
                            m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                            !ar_d, ar_d && !r_d);
                    end
                end
                if (m_axi_awvalid) begin total++; if (m_axi_awaddr !== addr) begin bad++; $display("FAIL awaddr: got %h want %h", m_axi_awaddr, addr); end end
                if (m_axi_wvalid)  begin total++; if (m_axi_wdata  !== data) begin bad++; $display("FAIL wdata: got %h want %h", m_axi_wdata, data); end end
                if (m_axi_arvalid) begin total++; if (m_axi_araddr !== addr) begin bad++; $display("FAIL araddr: got %h want %h", m_axi_araddr, addr); end end
                if (rsp_valid) begin
                    done = 1;
                    total++;
                    if (!(wr ? b_d : r_d)) begin bad++; $display("FAIL rsp_early: rsp_valid=1 before response handshake cyc%0d", cyc); end
                    total++;
                    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rsp_ready: cmd_ready=%b want 1", cmd_ready); end
                    total++;
                    if (rsp_rdata !== exp_rdata) begin bad++; $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, exp_rdata); end
                    total++;
                    if (rsp_resp !== resp) begin bad++; $display("FAIL rsp_resp: got %b want %b", rsp_resp, resp); end
                    if (chk_lat) begin
                        total++;
                        if (cyc != 4) begin bad++; $display("FAIL latency: rsp in cycle %0d want 4", cyc); end
                    end
                    last_rdata = exp_rdata; last_resp = resp;
                    if (wr && resp == RESP_OKAY) model_mem[addr] = data;
                end else begin
                    total++;
                    if ({cmd_ready, rsp_rdata, rsp_resp} !== {1'b0, last_rdata, last_resp}) begin
                        bad++; $display("FAIL busy_hold: ready,rdata,resp=%b,%h,%b want 0,%h,%b",
                            cmd_ready, rsp_rdata, rsp_resp, last_rdata, last_resp);
                    end
                end
                if (!done) begin
                    m_axi_rlast = 1'($urandom);
                    if (wr) begin
                        // Response only after both AW and W have completed.
                        if (aw_d && w_d && !b_d) begin
                            m_axi_bvalid = (b_w >= b_dly); b_w++;
                            m_axi_bresp  = resp;
                            if (m_axi_bvalid && m_axi_bready) begin
                                b_d = 1;
                                if (resp == RESP_OKAY) smem[cap_addr] = cap_data;
                            end
                        end else begin
                            m_axi_bvalid = 1'b0;
                        end
                        if (!aw_d && m_axi_awvalid) begin
                            m_axi_awready = (aw_w >= aw_dly); aw_w++;
                            if (m_axi_awready) begin aw_d = 1; cap_addr = m_axi_awaddr; end
                        end else m_axi_awready = 1'($urandom);
                        if (!w_d && m_axi_wvalid) begin
                            m_axi_wready = (w_w >= w_dly); w_w++;
                            if (m_axi_wready) begin w_d = 1; cap_data = m_axi_wdata; end
                        end else m_axi_wready = 1'($urandom);
                        m_axi_rvalid = stray_en && 1'($urandom);
                        m_axi_rdata  = 8'($urandom); m_axi_rresp = 2'($urandom);
                    end else begin
                        if (ar_d && !r_d) begin
                            m_axi_rvalid = (r_w >= r_dly); r_w++;
                            m_axi_rdata  = smem[cap_addr]; m_axi_rresp = resp;
                            if (m_axi_rvalid && m_axi_rready) r_d = 1;
                        end else begin
                            m_axi_rvalid = stray_en && 1'($urandom);
                            m_axi_rdata  = 8'($urandom); m_axi_rresp = 2'($urandom);
                        end
                        if (!ar_d && m_axi_arvalid) begin
                            m_axi_arready = (ar_w >= ar_dly); ar_w++;
                            if (m_axi_arready) begin ar_d = 1; cap_addr = m_axi_araddr; end
                        end else m_axi_arready = 1'($urandom);
                        m_axi_bvalid = stray_en && 1'($urandom);
                        m_axi_bresp  = 2'($urandom);
                    end
                end
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL timeout: no completion for %s addr %h within 60 cycles", wr ? "write" : "read", addr);
        end
        sub_idle();
    endtask

    task automatic test_reset();
        m_axi_resetn = 1'b0;
        sub_idle();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hA5; cmd_wdata = 8'h5A;
        repeat (3) @(negedge m_axi_clk);
        total++;
        if (out_vec() !== RST_VEC) begin bad++; $display("FAIL reset_state: outputs=%h want %h", out_vec(), RST_VEC); end
        cmd_valid = 1'b0;
        m_axi_resetn = 1'b1;
        @(negedge m_axi_clk);
        total++;
        if ({cmd_ready, rsp_valid, m_axi_awvalid} !== 3'b100) begin
            bad++; $display("FAIL reset_idle: ready,rsp,awvalid=%b%b%b want 100", cmd_ready, rsp_valid, m_axi_awvalid);
        end
    endtask

    task automatic test_zero_wait();
        set_dly(0, 0, 0, 0, 0); stray_en = 0;
        do_cmd(1'b1, 8'h10, 8'h3C, RESP_OKAY, 1'b1, 1'b0);
        do_cmd(1'b0, 8'h10, 8'h00, RESP_OKAY, 1'b1, 1'b0);
    endtask

    task automatic test_aw_late();
        set_dly(3, 0, 0, 0, 0); stray_en = 0;
        do_cmd(1'b1, 8'h22, 8'h5A, RESP_OKAY, 1'b0, 1'b0);
        set_dly(0, 2, 1, 0, 0);
        do_cmd(1'b1, 8'h23, 8'hC3, RESP_OKAY, 1'b0, 1'b0);
        set_dly(0, 0, 0, 0, 0);
        do_cmd(1'b0, 8'h22, 8'h00, RESP_OKAY, 1'b1, 1'b0);
        do_cmd(1'b0, 8'h23, 8'h00, RESP_OKAY, 1'b1, 1'b0);
    endtask

    task automatic test_r_stall();
        set_dly(0, 0, 0, 0, 5); stray_en = 1;
        do_cmd(1'b0, 8'h10, 8'h00, RESP_SLVERR, 1'b0, 1'b0);
        set_dly(0, 0, 2, 0, 0);
        do_cmd(1'b1, 8'h30, 8'h77, RESP_SLVERR, 1'b0, 1'b0);
        set_dly(0, 0, 0, 0, 0); stray_en = 0;
        do_cmd(1'b0, 8'h30, 8'h00, RESP_OKAY, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_dly(0, 0, 4, 0, 0); stray_en = 0;
        do_cmd(1'b1, 8'h44, 8'h99, RESP_OKAY, 1'b0, 1'b1);
        set_dly(0, 0, 0, 0, 0);
        do_cmd(1'b0, 8'h10, 8'h00, RESP_OKAY, 1'b1, 1'b0);
        do_cmd(1'b0, 8'h44, 8'h00, RESP_OKAY, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        set_dly(0, 0, 0, 0, 0); stray_en = 0;
        for (int i = 0; i < 6; i++) begin
            do_cmd(i[0], 8'(8'h50 + (i >> 1)), 8'(8'hE0 + i), RESP_OKAY, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        bit wr, lat;
        logic [1:0] resp;
        for (int i = 0; i < 60; i++) begin
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) set_dly(0, 0, 0, 0, 0);
            stray_en = 1'($urandom);
            wr   = 1'($urandom);
            resp = ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY;
            lat  = (aw_dly == 0 && w_dly == 0 && b_dly == 0 && ar_dly == 0 && r_dly == 0);
            do_cmd(wr, 8'($urandom_range(0, 7)), 8'($urandom), resp, lat, 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge m_axi_clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'h00;
            smem[i] = 8'h00;
        end
        last_rdata = 8'h00; last_resp = 2'b00;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        set_dly(0, 0, 0, 0, 0); stray_en = 0;
        sub_idle();
        test_reset();
        test_zero_wait();
        test_aw_late();
        test_r_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_csr_manager.md
AXI_CSR_MANAGER -- requirements
Module: axi_csr_manager

Interface
REQ-001 DATA_WIDTH, 8, data bus width in bits.
REQ-002 ADDR_WIDTH, 8, address width in bits.
REQ-003 m_axi_clk  in  1  sole clock, all logic on rising edge.
REQ-004 m_axi_resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  manager idle; command accepted when cmd_valid&&cmd_ready.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  ADDR_WIDTH  target address.
REQ-009 cmd_wdata  in  DATA_WIDTH  write data.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid, 0 for writes.
REQ-012 rsp_resp  out  2  BRESP/RRESP of completed transfer.
REQ-013 m_axi_awaddr  out  ADDR_WIDTH  write address.
REQ-014 m_axi_awvalid  out  1  write address valid.
REQ-015 m_axi_awready  in  1  write address ready.
REQ-016 m_axi_wdata  out  DATA_WIDTH  write data.
REQ-017 m_axi_wvalid  out  1  write data valid.
REQ-018 m_axi_wready  in  1  write data ready.
REQ-019 m_axi_wlast  out  1  always equal to m_axi_wvalid (single beat).
REQ-020 m_axi_bresp  in  2  write response.
REQ-021 m_axi_bvalid  in  1  write response valid.
REQ-022 m_axi_bready  out  1  write response ready.
REQ-023 m_axi_araddr  out  ADDR_WIDTH  read address.
REQ-024 m_axi_arvalid  out  1  read address valid.
REQ-025 m_axi_arready  in  1  read address ready.
REQ-026 m_axi_rdata  in  DATA_WIDTH  read data.
REQ-027 m_axi_rresp  in  2  read response.
REQ-028 m_axi_rvalid  in  1  read data valid.
REQ-029 m_axi_rready  out  1  read data ready.
REQ-030 m_axi_rlast  in  1  ignored; single-beat only.

Function
REQ-031 FSM states SHALL be IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA; cmd_ready=1 only in IDLE; one outstanding transfer max.
REQ-032 On accepted write: register addr/data, next cycle assert awvalid and wvalid together (WR_ADDR_DATA); each drops the cycle after its own handshake; AW and W may complete in either order or the same cycle.
REQ-033 Leave WR_ADDR_DATA only when both AW and W handshakes done; WR_RESP drives bready=1; bvalid&&bready -> capture bresp, rsp_valid=1 next cycle, return to IDLE.
REQ-034 On accepted read: RD_ADDR drives arvalid until arready; RD_DATA drives rready=1; rvalid&&rready -> capture rdata/rresp, rsp_valid=1 next cycle, to IDLE.
REQ-035 VALID signals SHALL never depend combinationally on READY and, once asserted, SHALL hold with stable addr/data until handshake.
REQ-036 bready/rready SHALL be 0 outside WR_RESP/RD_DATA; stray bvalid/rvalid ignored.
REQ-037 Latency with zero-wait subordinate: cmd accept -> rsp_valid = 4 cycles (write and read).
REQ-038 cmd_ready SHALL return to 1 in the same cycle rsp_valid pulses; back-to-back commands accepted then.
REQ-039 rsp_rdata/rsp_resp hold last value until next completion.

Reset
REQ-040 Reset mid-transfer SHALL immediately force IDLE; all valid/ready outputs 0, cmd_ready 1, rsp_valid 0, rsp_rdata 0, rsp_resp 0, addr/data outputs 0.
REQ-041 Outputs SHALL come from registers; first command accepted the first edge after resetn deasserts.

Structure
REQ-042 FSM state enum and AXI resp constants (OKAY=2'b00, SLVERR=2'b10) SHALL live in shared package axi_csr_pkg.
REQ-043 Single flat module; no sub-modules.

Verification
REQ-044 Write 0x3C->0x10, zero-wait subordinate -> awaddr=0x10, wdata=0x3C, wlast=1, rsp_valid at cycle 4, rsp_resp=00.
REQ-045 Read 0x10 after REQ-044 through dummy subordinate -> rsp_rdata=0x3C, rsp_resp=00.
REQ-046 wready 3 cycles before awready -> wvalid drops after W handshake, awvalid held with stable awaddr, single bready phase.
REQ-047 rvalid stalled 5 cycles, rresp=10 -> rready held, rsp_resp=10, cmd_ready low throughout.
REQ-048 resetn low during WR_RESP -> all valids/readies 0 same cycle, cmd_ready=1 after release, next read completes normally.
